// File: rtl/envelope_generator.sv
// Per-channel amplitude envelope: walks STEP/HOLD/JUMP/END entries in the shared
// sound ROM, one entry per enable strobe, and holds the 4-bit amplitude for the mixer.
module envelope_generator #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_data,
  output logic [3:0]            o_amplitude,
  output logic                  o_valid,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    DATA    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_STEP = 2'b00,
    OP_HOLD = 2'b01,
    OP_JUMP = 2'b10,
    OP_END  = 2'b11
  } op_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] base_reg, base_next;
  logic [ADDR_WIDTH-1:0] ptr_reg, ptr_next;
  op_t                   cur_op_reg, cur_op_next;
  op_t                   pend_op_reg, pend_op_next;
  logic [3:0]            amp_reg, amp_next;
  logic [3:0]            pend_amp_reg, pend_amp_next;
  logic                  jump_taken_reg, jump_taken_next;
  logic                  valid_reg, valid_next;
  op_t                   rom_op;

  assign rom_op = op_t'(i_rom_data[7:6]);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next      = state_reg;
    base_next       = base_reg;
    ptr_next        = ptr_reg;
    cur_op_next     = cur_op_reg;
    pend_op_next    = pend_op_reg;
    amp_next        = amp_reg;
    pend_amp_next   = pend_amp_reg;
    jump_taken_next = jump_taken_reg;
    valid_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_enable) begin
          if (i_load) begin
            base_next       = i_base_addr;
            ptr_next        = i_base_addr;
            jump_taken_next = 1'b0;
            state_next      = ADDR;
          end else if (cur_op_reg == OP_STEP) begin
            ptr_next        = ptr_reg + ADDR_WIDTH'(1);
            jump_taken_next = 1'b0;
            state_next      = ADDR;
          end else begin
            // HOLD/END re-report the current entry without touching the ROM.
            pend_op_next  = cur_op_reg;
            pend_amp_next = (cur_op_reg == OP_END) ? 4'd0 : amp_reg;
            state_next    = RESPOND;
          end
        end
      end
      ADDR: state_next = DATA;
      DATA: begin
        if (rom_op == OP_JUMP && !jump_taken_reg) begin
          ptr_next        = base_reg + ADDR_WIDTH'(i_rom_data[5:0]);
          jump_taken_next = 1'b1;
          state_next      = ADDR;
        end else if (rom_op == OP_JUMP) begin
          // A jump landing on another jump terminates the envelope.
          pend_op_next  = OP_END;
          pend_amp_next = 4'd0;
          state_next    = RESPOND;
        end else begin
          pend_op_next  = rom_op;
          pend_amp_next = (rom_op == OP_END) ? 4'd0 : i_rom_data[3:0];
          state_next    = RESPOND;
        end
      end
      RESPOND: begin
        amp_next    = pend_amp_reg;
        cur_op_next = pend_op_reg;
        valid_next  = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      base_reg       <= '0;
      ptr_reg        <= '0;
      cur_op_reg     <= OP_END;
      pend_op_reg    <= OP_END;
      amp_reg        <= 4'd0;
      pend_amp_reg   <= 4'd0;
      jump_taken_reg <= 1'b0;
      valid_reg      <= 1'b0;
    end else begin
      base_reg       <= base_next;
      ptr_reg        <= ptr_next;
      cur_op_reg     <= cur_op_next;
      pend_op_reg    <= pend_op_next;
      amp_reg        <= amp_next;
      pend_amp_reg   <= pend_amp_next;
      jump_taken_reg <= jump_taken_next;
      valid_reg      <= valid_next;
    end
  end

  assign o_rom_addr  = ptr_reg;
  assign o_amplitude = amp_reg;
  assign o_valid     = valid_reg;
  assign o_busy      = (state_reg != IDLE);

endmodule
